// File: rtl/led_mode_if.sv
// ============================================================================
// led_mode_if : valid/ready/data bundle between the mode master and the LED slave
// Rev 1.0
// ============================================================================
`default_nettype none

interface led_mode_if;
  logic       valid;
  logic       ready;
  logic [1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

`default_nettype wire

// File: rtl/led_mode_master.sv
// ============================================================================
// led_mode_master : debounced push-button advances a 2-bit blink mode and
// ships it downstream over valid/ready with a one-deep pending slot.
// Rev 1.0
// ============================================================================
`default_nettype none

module led_mode_master #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       btn_in,
  led_mode_if.master      bus,
  output logic [1:0]      mode,
  output logic            busy,
  output logic            overrun
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  logic             sync1_q;
  logic             btn_s_q;
  logic             btn_db_q;
  logic [CNT_W-1:0] cnt_q;
  logic             press_q;

  state_t           state_q;
  logic             valid_q;
  logic [1:0]       data_q;
  logic [1:0]       mode_q;
  logic             pend_q;
  logic             ovr_q;

  logic             w_hs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      btn_s_q <= 1'b0;
    end else begin
      sync1_q <= btn_in;
      btn_s_q <= sync1_q;
    end
  end

  // press_q is a registered one-cycle pulse on the debounced 0->1 transition
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      btn_db_q <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      press_q <= 1'b0;
      if (btn_s_q == btn_db_q) begin
        cnt_q <= '0;
      end else if (cnt_q == DB_LAST) begin
        cnt_q    <= '0;
        btn_db_q <= btn_s_q;
        press_q  <= btn_s_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign w_hs = valid_q & bus.ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      data_q  <= 2'b00;
      mode_q  <= 2'b00;
      pend_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (press_q) begin
            data_q  <= mode_q + 2'd1;
            valid_q <= 1'b1;
            state_q <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (w_hs) begin
            mode_q <= data_q;
            // A press coinciding with the handshake is treated as arriving after it
            if (pend_q || press_q) begin
              data_q <= data_q + 2'd1;
              pend_q <= pend_q & press_q;
            end else begin
              valid_q <= 1'b0;
              state_q <= ST_IDLE;
            end
          end else if (press_q) begin
            if (pend_q) ovr_q  <= 1'b1;
            else        pend_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.valid = valid_q;
  assign bus.data  = data_q;
  assign mode      = mode_q;
  assign busy      = valid_q;
  assign overrun   = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_led_mode_master.sv
// ============================================================================
// tb_led_mode_master : directed presses against a registered-ready slave model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_led_mode_master;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_in = 1'b0;
  logic       slave_en = 1'b1;
  logic [1:0] mode;
  logic       busy;
  logic       overrun;

  int n_vec  = 0;
  int n_fail = 0;
  int n_rise = 0;
  int n_fall = 0;

  logic [1:0] sb[$];
  logic       mode_chk = 1'b0;
  logic [1:0] mode_exp = 2'b00;
  logic       valid_prev = 1'b0;

  led_mode_if bus ();

  led_mode_master #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_in  (btn_in),
    .bus     (bus),
    .mode    (mode),
    .busy    (busy),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  // Downstream slave registers ready from valid
  always @(posedge clk or posedge rst) begin
    if (rst) bus.ready <= 1'b0;
    else     bus.ready <= slave_en & bus.valid;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a valid&&ready seen at the falling edge completes on the next rising edge
  always @(negedge clk) begin
    if (rst) begin
      mode_chk   = 1'b0;
      valid_prev = 1'b0;
    end else begin
      if (bus.valid && !valid_prev) n_rise++;
      if (!bus.valid && valid_prev) n_fall++;
      valid_prev = bus.valid;
      if (mode_chk) begin
        chk("mode_after_hs", int'(mode), int'(mode_exp));
        mode_chk = 1'b0;
      end
      if (bus.valid && bus.ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_transfer", int'(bus.data), -1);
        end else begin
          mode_exp = sb.pop_front();
          chk("xfer_data", int'(bus.data), int'(mode_exp));
          mode_chk = 1'b1;
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
  endtask

  task automatic pulse(input int hi, input int lo);
    @(negedge clk);
    btn_in = 1'b1;
    cycles(hi);
    btn_in = 1'b0;
    cycles(lo);
  endtask

  task automatic wait_valid(input int max);
    int k;
    k = 0;
    while (!bus.valid && k < max) begin
      @(negedge clk);
      k++;
    end
    chk("wait_valid_timeout", int'(bus.valid), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int f0;

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_valid", int'(bus.valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_data", int'(bus.data), 0);
    chk("rst_mode", int'(mode), 0);
    chk("rst_overrun", int'(overrun), 0);

    // Single press: valid exactly 6 edges after first sample
    sb.push_back(2'b01);
    btn_in = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1 chk("latency_valid_e5", int'(bus.valid), 0);
    @(posedge clk);
    #1 chk("latency_valid_e6", int'(bus.valid), 1);
    chk("first_data", int'(bus.data), 1);
    chk("first_busy", int'(busy), 1);
    @(posedge clk);
    #1 chk("ready_follows", int'(bus.ready), 1);
    chk("valid_held", int'(bus.valid), 1);
    @(posedge clk);
    #1 chk("valid_fall_after_hs", int'(bus.valid), 0);
    chk("mode_01", int'(mode), 1);
    btn_in = 1'b0;
    cycles(10);
    chk("single_overrun", int'(overrun), 0);

    // Glitch of 3 cycles must be rejected
    r0 = n_rise;
    pulse(3, 15);
    chk("glitch_no_valid", n_rise - r0, 0);
    chk("glitch_mode", int'(mode), 1);
    // 4-cycle pulse produces exactly one transfer
    sb.push_back(2'b10);
    pulse(4, 15);
    chk("pulse4_one_xfer", n_rise - r0, 1);
    chk("pulse4_mode", int'(mode), 2);

    // Wrap-around from reset
    do_reset();
    sb.push_back(2'b01);
    sb.push_back(2'b10);
    sb.push_back(2'b11);
    sb.push_back(2'b00);
    repeat (4) pulse(8, 8);
    cycles(4);
    chk("wrap_sb_empty", sb.size(), 0);
    chk("wrap_mode", int'(mode), 0);

    // Pending and back-to-back with stalled slave
    do_reset();
    slave_en = 1'b0;
    sb.push_back(2'b01);
    sb.push_back(2'b10);
    pulse(8, 8);
    pulse(8, 8);
    chk("pend_valid_stalled", int'(bus.valid), 1);
    chk("pend_data_stalled", int'(bus.data), 1);
    f0 = n_fall;
    slave_en = 1'b1;
    cycles(10);
    chk("b2b_single_fall", n_fall - f0, 1);
    chk("b2b_mode", int'(mode), 2);
    chk("b2b_overrun", int'(overrun), 0);
    chk("b2b_sb_empty", sb.size(), 0);

    // Overrun: three presses while stalled
    do_reset();
    slave_en = 1'b0;
    sb.push_back(2'b01);
    sb.push_back(2'b10);
    pulse(8, 8);
    pulse(8, 8);
    chk("ovr_before_third", int'(overrun), 0);
    pulse(8, 8);
    chk("ovr_after_third", int'(overrun), 1);
    slave_en = 1'b1;
    cycles(12);
    chk("ovr_sb_empty", sb.size(), 0);
    chk("ovr_mode", int'(mode), 2);
    chk("ovr_idle", int'(bus.valid), 0);
    chk("ovr_sticky", int'(overrun), 1);

    // Reset mid-transfer: outputs clear without a clock edge
    slave_en = 1'b0;
    pulse(8, 0);
    wait_valid(20);
    chk("mid_data", int'(bus.data), 3);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", int'(bus.valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_data", int'(bus.data), 0);
    chk("mid_rst_mode", int'(mode), 0);
    chk("mid_rst_overrun", int'(overrun), 0);
    @(negedge clk);
    rst = 1'b0;
    slave_en = 1'b1;
    cycles(20);
    chk("post_rst_valid", int'(bus.valid), 0);
    chk("post_rst_mode", int'(mode), 0);
    chk("final_sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/led_mode_master.md
# led_mode_master

Upstream source for the fabric LED blinker's slave handshake stage. Samples a raw push-button, synchronises and debounces it, and advances a 2-bit blink mode on each press. Each new mode goes to the downstream slave over a valid/ready handshake with a one-deep pending queue and overrun flag. The downstream slave registers `ready` from `valid`, so `ready` rises one cycle after `valid`.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable cycles required before the debounced level changes. Must be ≥ 2.
- `CNT_W`, default 16: debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- `clk`  in  1: single clock for all logic.
- `rst`  in  1: asynchronous, active-high reset.
- `btn_in`  in  1: raw push-button, asynchronous to `clk`, active-high when pressed.
- `valid`  out  1: transfer request to the downstream slave.
- `ready`  in  1: downstream acceptance.
- `data`  out  2: mode being transferred (00/01/10/11 select LED 1/2/3/4).
- `mode`  out  2: last mode accepted by downstream.
- `busy`  out  1: high while a transfer is outstanding (equal to `valid`).
- `overrun`  out  1: sticky; a press was dropped.

## Operation

Reset (async, `rst`=1):
- `valid`=0, `busy`=0, `data`=00, `mode`=00, `overrun`=0.
- pending=0, debounce counter=0, sync flops=0, debounced level=0, FSM=IDLE.
- Asserting reset mid-transfer drops `valid` immediately. No transfer completes.

Synchroniser: two flops in series; second flop output is `btn_s`.

Debounce:
- Counter clears whenever `btn_s` equals the debounced level `btn_db`.
- Counter increments each cycle `btn_s` ≠ `btn_db`.
- When the counter equals DEBOUNCE_CYCLES−1 and `btn_s` ≠ `btn_db` still holds: `btn_db` ← `btn_s`, counter ← 0.
- A glitch shorter than DEBOUNCE_CYCLES cycles at `btn_s` never changes `btn_db`.

Press event: one-cycle pulse on a `btn_db` 0→1 transition. Release generates no event.

Handshake FSM, states IDLE and SEND:
- **IDLE, press:** `data` ← `mode`+1 (mod 4; 11→00 wraps), `valid` ← 1, go to SEND.
- **SEND:** `valid` and `data` are held stable until `valid`&&`ready` is sampled at a clock edge (the handshake). At handshake, `mode` ← `data`.
  - pending=0: `valid` ← 0, go to IDLE.
  - pending=1: `data` ← `data`+1 (mod 4), `valid` stays 1, pending ← 0, stay in SEND (back-to-back transfer).
- **Press while in SEND:**
  - pending=0: pending ← 1.
  - pending=1: press dropped, `overrun` ← 1.
- **Press on the same edge as a handshake:** counted as arriving after the handshake.
  - pending was 0: pending ← 1 if the FSM goes to IDLE; becomes the back-to-back follow-up otherwise.
  - Never raises `overrun` unless pending remains 1 after the update.
- `overrun` clears only on reset.
- `ready` while `valid`=0 is ignored. The slave's trailing `ready` cycle after `valid` falls is not a handshake.

## Timing

- `btn_in` first sampled high at edge 0 and held:
  - `btn_s` high after edge 1.
  - `btn_db` high after edge 1+DEBOUNCE_CYCLES.
  - `valid` high after edge 2+DEBOUNCE_CYCLES.
- With the registered-ready slave:
  - `ready` rises one cycle after `valid`.
  - Handshake occurs on the next edge; `valid` is low after that edge.
  - Transfer occupies 2 cycles of `valid`.
- Back-to-back transfer: `ready` is already high, so the second handshake completes on the first edge after `data` changes. `valid` stays high 1 extra cycle.
- `mode` updates on the handshake edge, visible the following cycle.
- `data` changes only on the edge that asserts `valid` or on a handshake edge.

## Test plan

Benches use DEBOUNCE_CYCLES=4.
- **Reset and single press:** reset, then hold `btn_in`=1. Required: `valid` rises exactly 6 edges after first sample with `data`=01. `ready` follows one cycle later. `valid` falls after handshake, `mode`=01, `overrun`=0.
- **Glitch rejection:** `btn_in` high for 3 cycles then low. Required: `btn_db` never rises, `valid` stays 0. A 4-cycle-stable pulse must produce exactly one transfer.
- **Wrap-around:** four clean presses with slave attached. Required: `data` sequence 01,10,11,00 and final `mode`=00.
- **Pending and back-to-back:** hold `ready`=0 (stalled slave), make two presses, then release `ready`. Required: first transfer `data`=01, then `valid` held continuously with `data`=10. `mode` ends 10, `overrun`=0.
- **Overrun:** three presses while `ready` is held 0. Required: `overrun`=1 after third press. Only `data`=01 and 10 are transferred.
- **Reset mid-transfer:** assert `rst` while `valid`=1 and `ready`=0. Required: `valid`, `busy`, `data`, `mode` and `overrun` go to 0/00 immediately without a clock edge. No transfer completes after release.
